// File: rtl/expstate_irq_pkg.sv
// Shared types and default configuration for the exported-state interrupt bridge.
package expstate_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } irq_state_e;

  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_STATE_W = 32;
  localparam int unsigned DEF_CH_BASE = 0;
  localparam int unsigned DEF_HOLDOFF = 3;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned HCNT_W      = 8;

endpackage

// File: rtl/expstate_irq_chan.sv
// One interrupt channel: event register, IDLE/PEND/HOLD sequencer, one-deep
// hold-off latch and sticky lost-event accounting.
module expstate_irq_chan
  import expstate_irq_pkg::*;
#(
  parameter bit          EDGE    = 1'b1,
  parameter int unsigned HOLDOFF = DEF_HOLDOFF,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_s1,
  input  logic             i_s2,
  input  logic             i_en,
  input  logic             i_ack,
  output logic             o_irq,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_miss
);

  localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  irq_state_e        r_state;
  irq_state_e        w_state_nxt;
  logic [HCNT_W-1:0] r_hcnt;
  logic [HCNT_W-1:0] w_hcnt_nxt;
  logic              r_evt;
  logic              w_evt_e;
  logic              r_latch;
  logic              w_latch_nxt;
  logic              w_miss_evt;
  logic              r_irq;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_miss;

  // Level channels never latch or overflow: a held level simply re-triggers from IDLE.
  assign w_evt_e = EDGE & r_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_evt <= 1'b0;
    else        r_evt <= (EDGE ? (i_s1 & ~i_s2) : i_s1) & i_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_latch <= 1'b0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_latch <= w_latch_nxt;
      r_irq   <= (w_state_nxt == PEND);
      r_ovf   <= r_ovf | w_miss_evt;
      if (w_miss_evt && (r_miss != {CNT_W{1'b1}})) r_miss <= r_miss + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_latch_nxt = r_latch;
    w_miss_evt  = 1'b0;
    case (r_state)
      IDLE: if (r_evt) w_state_nxt = PEND;
      PEND: begin
        if (i_ack) begin
          // An event coincident with the ack is carried forward, never counted as lost.
          if (HOLDOFF == 0) begin
            w_state_nxt = w_evt_e ? PEND : IDLE;
          end else begin
            w_state_nxt = HOLD;
            w_hcnt_nxt  = HOLD_LOAD;
            w_latch_nxt = w_evt_e;
          end
        end else if (w_evt_e) begin
          w_miss_evt = 1'b1;
        end
      end
      HOLD: begin
        if (w_evt_e) begin
          if (r_latch) w_miss_evt  = 1'b1;
          else         w_latch_nxt = 1'b1;
        end
        if (r_hcnt == '0) begin
          w_state_nxt = (r_latch | w_evt_e) ? PEND : IDLE;
          w_latch_nxt = 1'b0;
        end else begin
          w_hcnt_nxt = r_hcnt - HCNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_irq  = r_irq;
  assign o_ovf  = r_ovf;
  assign o_miss = r_miss;

endmodule

// File: rtl/expstate_irq_bridge.sv
// Turns bits of a producer core's exported state into level interrupts for a
// consumer core; holds only the S1/S2 sampling stages and per-channel slicing.
module expstate_irq_bridge
  import expstate_irq_pkg::*;
#(
  parameter int unsigned       NUM_CH    = DEF_NUM_CH,
  parameter int unsigned       STATE_W   = DEF_STATE_W,
  parameter int unsigned       CH_BASE   = DEF_CH_BASE,
  parameter logic [NUM_CH-1:0] EDGE_MODE = {NUM_CH{1'b1}},
  parameter int unsigned       HOLDOFF   = DEF_HOLDOFF,
  parameter int unsigned       CNT_W     = DEF_CNT_W
) (
  input  logic                    CLK,
  input  logic                    BResetN,
  input  logic [STATE_W-1:0]      TIE_EXPSTATE,
  input  logic [NUM_CH-1:0]       IrqAck,
  input  logic [NUM_CH-1:0]       IrqEnable,
  output logic [NUM_CH-1:0]       BInterrupt,
  output logic [NUM_CH-1:0]       IrqOverflow,
  output logic [NUM_CH*CNT_W-1:0] MissCount
);

  logic [NUM_CH-1:0] w_bits;
  logic [NUM_CH-1:0] r_s1;
  logic [NUM_CH-1:0] r_s2;
  logic              r_primed;
  logic              w_unused_state;

  assign w_bits         = TIE_EXPSTATE[CH_BASE +: NUM_CH];
  assign w_unused_state = ^TIE_EXPSTATE;

  // First cycle after reset loads S1 and S2 together so a bit already high is not an edge.
  always_ff @(posedge CLK) begin
    if (!BResetN) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_primed <= 1'b0;
    end else begin
      r_s1     <= w_bits;
      r_s2     <= r_primed ? r_s1 : w_bits;
      r_primed <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    expstate_irq_chan #(
      .EDGE    (EDGE_MODE[g]),
      .HOLDOFF (HOLDOFF),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk    (CLK),
      .rst_n  (BResetN),
      .i_s1   (r_s1[g]),
      .i_s2   (r_s2[g]),
      .i_en   (IrqEnable[g]),
      .i_ack  (IrqAck[g]),
      .o_irq  (BInterrupt[g]),
      .o_ovf  (IrqOverflow[g]),
      .o_miss (MissCount[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_expstate_irq_bridge.sv
// Bench for expstate_irq_bridge: default instance plus a HOLDOFF=0/CNT_W=2/level-ch0
// instance, checked every cycle against a cycle-level behavioural model.
module tb_expstate_irq_bridge;

  logic        CLK = 1'b0;
  logic        rstn;
  logic [31:0] tie [2];
  logic [3:0]  ack [2];
  logic [3:0]  en  [2];
  logic [3:0]  bint0, bint1, ovf0, ovf1;
  logic [31:0] miss0;
  logic [7:0]  miss1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  expstate_irq_bridge #(
    .NUM_CH(4), .STATE_W(32), .CH_BASE(0), .EDGE_MODE(4'hF), .HOLDOFF(3), .CNT_W(8)
  ) u_dut0 (
    .CLK(CLK), .BResetN(rstn), .TIE_EXPSTATE(tie[0]), .IrqAck(ack[0]), .IrqEnable(en[0]),
    .BInterrupt(bint0), .IrqOverflow(ovf0), .MissCount(miss0)
  );

  expstate_irq_bridge #(
    .NUM_CH(4), .STATE_W(32), .CH_BASE(0), .EDGE_MODE(4'hE), .HOLDOFF(0), .CNT_W(2)
  ) u_dut1 (
    .CLK(CLK), .BResetN(rstn), .TIE_EXPSTATE(tie[1]), .IrqAck(ack[1]), .IrqEnable(en[1]),
    .BInterrupt(bint1), .IrqOverflow(ovf1), .MissCount(miss1)
  );

  // Model configuration and state (0 = idle, 1 = pending, 2 = hold-off)
  int         M_HOLD [2] = '{3, 0};
  int         M_CMAX [2] = '{255, 3};
  logic [3:0] M_EDGE [2] = '{4'hF, 4'hE};

  int          m_st   [2][4];
  int          m_rem  [2][4];
  int          m_miss [2][4];
  bit          m_lat  [2][4];
  bit          m_ovf  [2][4];
  logic [31:0] h_tie  [2][1:3];
  logic [3:0]  h_en   [2];
  logic        h_rst  [1:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic lost(input int i, input int c);
    m_ovf[i][c] = 1'b1;
    if (m_miss[i][c] < M_CMAX[i]) m_miss[i][c]++;
  endtask

  // Advance the model over the next clock edge using the inputs now being driven.
  task automatic model_step();
    logic ev;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (M_EDGE[i][c])
          ev = h_rst[1] & h_rst[2] & h_rst[3] & h_tie[i][2][c] & ~h_tie[i][3][c] & h_en[i][c];
        else
          ev = h_rst[1] & h_rst[2] & h_tie[i][2][c] & h_en[i][c];
        if (!rstn) begin
          m_st[i][c] = 0; m_rem[i][c] = 0; m_lat[i][c] = 0; m_ovf[i][c] = 0; m_miss[i][c] = 0;
        end else if (M_EDGE[i][c]) begin
          case (m_st[i][c])
            0: if (ev) m_st[i][c] = 1;
            1: begin
              if (ack[i][c]) begin
                if (M_HOLD[i] == 0) m_st[i][c] = ev ? 1 : 0;
                else begin m_st[i][c] = 2; m_rem[i][c] = M_HOLD[i]; m_lat[i][c] = ev; end
              end else if (ev) lost(i, c);
            end
            default: begin
              if (ev) begin
                if (m_lat[i][c]) lost(i, c);
                else m_lat[i][c] = 1'b1;
              end
              m_rem[i][c]--;
              if (m_rem[i][c] == 0) begin
                m_st[i][c] = m_lat[i][c] ? 1 : 0;
                m_lat[i][c] = 1'b0;
              end
            end
          endcase
        end else begin
          case (m_st[i][c])
            0: if (ev) m_st[i][c] = 1;
            1: if (ack[i][c]) begin
              if (M_HOLD[i] == 0) m_st[i][c] = 0;
              else begin m_st[i][c] = 2; m_rem[i][c] = M_HOLD[i]; end
            end
            default: begin
              m_rem[i][c]--;
              if (m_rem[i][c] == 0) m_st[i][c] = 0;
            end
          endcase
        end
      end
      h_tie[i][3] = h_tie[i][2];
      h_tie[i][2] = h_tie[i][1];
      h_tie[i][1] = tie[i];
      h_en[i]     = en[i];
    end
    h_rst[3] = h_rst[2];
    h_rst[2] = h_rst[1];
    h_rst[1] = rstn;
  endtask

  function automatic logic [3:0] dut_irq(input int i);
    return (i == 0) ? bint0 : bint1;
  endfunction

  function automatic logic [3:0] dut_ovf(input int i);
    return (i == 0) ? ovf0 : ovf1;
  endfunction

  function automatic logic [31:0] dut_miss(input int i, input int c);
    return (i == 0) ? 32'(miss0[c*8 +: 8]) : 32'(miss1[c*2 +: 2]);
  endfunction

  // Compare every output against the model just after each active edge.
  always begin
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("m%0d_irq%0d", i, c), 32'(dut_irq(i)[c]), 32'(m_st[i][c] == 1));
        check($sformatf("m%0d_ovf%0d", i, c), 32'(dut_ovf(i)[c]), 32'(m_ovf[i][c]));
        check($sformatf("m%0d_miss%0d", i, c), dut_miss(i, c), 32'(m_miss[i][c]));
      end
    end
  end

  task automatic step_in();
    model_step();
    @(negedge CLK);
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tie[i] = '0; ack[i] = '0; en[i] = 4'hF; h_en[i] = '0;
      for (int k = 1; k <= 3; k++) h_tie[i][k] = '0;
      for (int c = 0; c < 4; c++) begin
        m_st[i][c] = 0; m_rem[i][c] = 0; m_miss[i][c] = 0; m_lat[i][c] = 0; m_ovf[i][c] = 0;
      end
    end
    for (int k = 1; k <= 3; k++) h_rst[k] = 1'b0;

    step_in(); step_in();
    check("rst_irq0", 32'(bint0), 32'd0);
    check("rst_ovf0", 32'(ovf0), 32'd0);
    check("rst_miss0", miss0, 32'd0);
    check("rst_irq1", 32'(bint1), 32'd0);
    rstn = 1'b1;
    repeat (3) step_in();

    // Single-cycle pulse on bit 0: interrupt two edges later, held until ack, 3-cycle hold-off
    tie[0][0] = 1'b1; step_in();
    tie[0][0] = 1'b0; step_in();
    check("pulse_t1", 32'(bint0[0]), 32'd0);
    step_in();
    check("pulse_t2", 32'(bint0[0]), 32'd1);
    repeat (2) step_in();
    check("pulse_held", 32'(bint0[0]), 32'd1);
    ack[0][0] = 1'b1; step_in(); ack[0][0] = 1'b0;
    check("pulse_ackdrop", 32'(bint0[0]), 32'd0);
    repeat (2) step_in();
    check("pulse_holdlow", 32'(bint0[0]), 32'd0);
    check("pulse_miss", miss0, 32'd0);

    // Four rises on bit 1 while pending: three lost
    for (int k = 0; k < 4; k++) begin
      tie[0][1] = 1'b1; step_in();
      tie[0][1] = 1'b0; step_in();
    end
    repeat (2) step_in();
    check("ovf_flag1", 32'(ovf0[1]), 32'd1);
    check("ovf_miss1", 32'(miss0[15:8]), 32'd3);
    ack[0][1] = 1'b1; step_in(); ack[0][1] = 1'b0;
    repeat (4) step_in();

    // Rise on bit 2 coincident with ack: latched, reasserts after 3 low cycles
    tie[0][2] = 1'b1; step_in();
    tie[0][2] = 1'b0; repeat (2) step_in();
    check("hold_pend2", 32'(bint0[2]), 32'd1);
    ack[0][2] = 1'b1; tie[0][2] = 1'b1; step_in();
    ack[0][2] = 1'b0; tie[0][2] = 1'b0;
    check("hold_low_a", 32'(bint0[2]), 32'd0);
    step_in();
    check("hold_low_b", 32'(bint0[2]), 32'd0);
    step_in();
    check("hold_low_c", 32'(bint0[2]), 32'd0);
    step_in();
    check("hold_reassert", 32'(bint0[2]), 32'd1);
    check("hold_noovf", 32'(ovf0[2]), 32'd0);
    ack[0][2] = 1'b1; step_in(); ack[0][2] = 1'b0;
    repeat (4) step_in();

    // Level channel 0 of the second instance, held high and acked constantly
    tie[1][0] = 1'b1; ack[1][0] = 1'b1;
    repeat (2) step_in();
    for (int k = 0; k < 4; k++) begin
      step_in();
      check($sformatf("lvl_toggle%0d", k), 32'(bint1[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    tie[1][0] = 1'b0; repeat (3) step_in();
    ack[1][0] = 1'b0; repeat (2) step_in();
    check("lvl_miss", 32'(miss1[1:0]), 32'd0);

    // Six rises on channel 3 with a 2-bit counter: saturates at 3
    for (int k = 0; k < 6; k++) begin
      tie[1][3] = 1'b1; step_in();
      tie[1][3] = 1'b0; step_in();
    end
    repeat (2) step_in();
    check("sat_miss3", 32'(miss1[7:6]), 32'd3);
    check("sat_ovf3", 32'(ovf1[3]), 32'd1);
    ack[1][3] = 1'b1; step_in(); ack[1][3] = 1'b0; step_in();

    // Reset while pending with all bits held high: no edge after release
    tie[0] = 32'hFFFF_FFFF; repeat (3) step_in();
    check("rstp_pend", 32'(bint0), 32'hF);
    rstn = 1'b0; step_in();
    check("rstp_irq", 32'(bint0), 32'd0);
    check("rstp_ovf", 32'(ovf0), 32'd0);
    check("rstp_miss", miss0, 32'd0);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step_in();
      check($sformatf("rstp_noedge%0d", k), 32'(bint0), 32'd0);
    end
    tie[0] = '0; repeat (3) step_in();

    // Randomised traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 4; c++) if ($urandom_range(3) == 0) tie[i][c] = ~tie[i][c];
        tie[i][31:4] = 28'($urandom);
        ack[i] = 4'($urandom & $urandom);
        en[i]  = ~4'($urandom & $urandom & $urandom);
      end
      rstn = ($urandom_range(199) != 0);
      step_in();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expstate_irq_bridge.md
EXPSTATE_IRQ_BRIDGE -- requirements
Module: expstate_irq_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of interrupt channels, legal range 1..16.
REQ-002 SHALL have parameter STATE_W, default 32: width of the exported TIE state bus.
REQ-003 SHALL have parameter CH_BASE, default 0: TIE_EXPSTATE bit index of channel 0; channel i uses bit CH_BASE+i; CH_BASE+NUM_CH SHALL be <= STATE_W.
REQ-004 SHALL have parameter EDGE_MODE, default {NUM_CH{1'b1}}: per channel, 1 = rising-edge event, 0 = level event.
REQ-005 SHALL have parameter HOLDOFF, default 3: re-arm lockout in cycles after acknowledge, legal range 0..255.
REQ-006 SHALL have parameter CNT_W, default 8: width of each missed-event counter.
REQ-007 CLK  input  1  single clock; all state updates on its rising edge.
REQ-008 BResetN  input  1  reset, synchronous, active-low.
REQ-009 TIE_EXPSTATE  input  STATE_W  exported state from the producer core.
REQ-010 IrqAck  input  NUM_CH  per-channel acknowledge from the consumer core, sampled each cycle.
REQ-011 IrqEnable  input  NUM_CH  per-channel enable; 0 suppresses event capture.
REQ-012 BInterrupt  output  NUM_CH  level interrupt to the consumer core.
REQ-013 IrqOverflow  output  NUM_CH  sticky flag: an event was lost on this channel.
REQ-014 MissCount  output  NUM_CH*CNT_W  per-channel saturating lost-event count; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-015 TIE_EXPSTATE bits SHALL be registered once (stage S1) before event detection; a second register (S2) holds the previous S1 value.
REQ-016 Edge event SHALL be S1 & ~S2; level event SHALL be S1; both SHALL be gated by IrqEnable.
REQ-017 Each channel SHALL implement FSM IDLE, PEND, HOLD.
REQ-018 IDLE -> PEND on event; BInterrupt SHALL be high exactly while in PEND.
REQ-019 Latency: an edge-mode bit rising before clock edge t SHALL assert BInterrupt after edge t+2.
REQ-020 PEND -> HOLD when IrqAck is high; BInterrupt SHALL deassert on the following cycle.
REQ-021 HOLD SHALL last exactly HOLDOFF cycles, then -> IDLE; HOLDOFF=0 SHALL go PEND -> IDLE directly on ack.
REQ-022 An event during HOLD SHALL be latched (one deep) and SHALL cause HOLD -> PEND instead of HOLD -> IDLE.
REQ-023 An event while in PEND, or a second event while the HOLD latch is already set, SHALL set IrqOverflow and increment MissCount, saturating at 2^CNT_W-1.
REQ-024 In PEND, simultaneous IrqAck and event SHALL take the ack transition and latch the event into HOLD (HOLDOFF=0: stay in PEND); it SHALL NOT count as overflow.
REQ-025 IrqAck outside PEND SHALL be ignored.
REQ-026 Deasserting IrqEnable SHALL NOT clear PEND; it SHALL only block new events.
REQ-027 Level mode SHALL re-enter PEND after HOLD if the bit is still high; no overflow SHALL be counted while the level stays high in PEND.
REQ-028 IrqOverflow and MissCount SHALL clear only on reset.

Reset
REQ-029 While BResetN is low at a clock edge: all FSMs SHALL go to IDLE, S1/S2, HOLD counters and latches SHALL clear, and BInterrupt, IrqOverflow and MissCount SHALL be 0.
REQ-030 Reset mid-PEND or mid-HOLD SHALL drop BInterrupt on the next cycle; a bit already high at reset release SHALL NOT produce an edge event (S1/S2 reload together on the first cycle after reset).

Structure
REQ-031 Package expstate_irq_pkg SHALL hold the FSM state enum (IDLE, PEND, HOLD) and the default parameter constants.
REQ-032 Per-channel logic SHALL live in sub-module expstate_irq_chan, instantiated NUM_CH times by a generate loop; the top level SHALL hold only S1/S2 and bit slicing.

Verification
REQ-033 Default params: bit 0 pulsed high for 1 cycle -> BInterrupt[0]=1 two edges later, held until IrqAck[0]; then low for 3 cycles; MissCount[0]=0.
REQ-034 Bit 1 rises 3 times while BInterrupt[1] is pending -> IrqOverflow[1]=1, MissCount[1]=3.
REQ-035 Edge on bit 2 during HOLD -> BInterrupt[2] reasserts exactly 3 cycles after the ack deassert; no overflow.
REQ-036 CNT_W=2, 5 overflow events on channel 3 -> MissCount[3]=3 (saturated).
REQ-037 EDGE_MODE=0 on channel 0, bit held high, HOLDOFF=0, acked every PEND cycle -> BInterrupt[0] toggles 1,0,1,0; MissCount[0]=0.
REQ-038 BResetN low for 1 cycle in PEND with TIE_EXPSTATE=0xFFFFFFFF held -> all outputs 0; no edge interrupts after release.
